// File: rtl/fsm_detect_arbiter_if.sv
// Requester/consumer bundle for fsm_detect_arbiter: per-requester request, symbol stream
// and burst flags in; grant, ready, detector and result outputs back.
interface fsm_detect_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       i_req;
  logic [1:0]       i_valid;
  logic [1:0]       i_sym0;
  logic [1:0]       i_sym1;
  logic [1:0]       i_last;
  logic [1:0]       o_gnt;
  logic             o_ready;
  logic             o_match;
  logic             o_done;
  logic             o_gid;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_req, i_valid, i_sym0, i_sym1, i_last,
    input  o_gnt, o_ready, o_match, o_done, o_gid, o_count
  );

  modport slave (
    input  i_req, i_valid, i_sym0, i_sym1, i_last,
    output o_gnt, o_ready, o_match, o_done, o_gid, o_count
  );
endinterface

// File: rtl/fsm_detect_arbiter.sv
// Round-robin shares one two-in-a-row detector between two symbol requesters; grant one cycle
// after request, o_done one cycle after the last symbol; symbols taken whenever i_valid[g] is high.
module fsm_detect_arbiter #(
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rstn,
  fsm_detect_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_t;
  typedef enum logic [2:0] {INIT, A0, A1, OK0, OK1} det_t;

  ctrl_t            ctrl, nxt_ctrl;
  det_t             det, nxt_det, det_step;
  logic [1:0]       gnt, nxt_gnt;
  logic             gid_cur, nxt_gid_cur;
  logic             gid_out, nxt_gid_out;
  logic             ptr, nxt_ptr;
  logic [CNT_W-1:0] count, nxt_count;

  logic       pick;
  logic       g_req, g_valid, g_last;
  logic [1:0] g_sym;

  function automatic det_t det_next(input det_t s, input logic [1:0] sym);
    det_t r;
    case (s)
      INIT:    r = sym[1] ? A1 : A0;
      A0:      r = sym[1] ? A1 : OK0;
      A1:      r = sym[1] ? OK1 : A0;
      OK0:     r = !sym[1] ? OK0 : (sym[0] ? OK1 : A1);
      OK1:     r = sym[1] ? OK1 : (sym[0] ? OK0 : A0);
      default: r = INIT;
    endcase
    return r;
  endfunction

  assign g_req    = bus.i_req[gid_cur];
  assign g_valid  = bus.i_valid[gid_cur];
  assign g_last   = bus.i_last[gid_cur];
  assign g_sym    = gid_cur ? bus.i_sym1 : bus.i_sym0;
  assign det_step = det_next(det, g_sym);
  // Pointer-favoured requester wins only if it is actually asking.
  assign pick     = bus.i_req[ptr] ? ptr : ~ptr;

  always_comb begin
    nxt_ctrl    = ctrl;
    nxt_det     = det;
    nxt_gnt     = gnt;
    nxt_gid_cur = gid_cur;
    nxt_gid_out = gid_out;
    nxt_ptr     = ptr;
    nxt_count   = count;
    case (ctrl)
      IDLE: begin
        if (|bus.i_req) begin
          nxt_gid_cur = pick;
          nxt_gnt     = pick ? 2'b10 : 2'b01;
          nxt_count   = '0;
          nxt_det     = INIT;
          nxt_ctrl    = RUN;
        end
      end
      RUN: begin
        if (!g_req) begin
          nxt_ctrl = IDLE;
          nxt_gnt  = 2'b00;
          nxt_ptr  = ~gid_cur;
        end else if (g_valid) begin
          nxt_det = det_step;
          if ((det_step == OK0 || det_step == OK1) && count != {CNT_W{1'b1}})
            nxt_count = count + CNT_W'(1);
          if (g_last) begin
            nxt_ctrl    = DONE;
            nxt_gnt     = 2'b00;
            nxt_gid_out = gid_cur;
          end
        end
      end
      DONE: begin
        nxt_ptr  = ~gid_cur;
        nxt_ctrl = IDLE;
      end
      default: begin
        nxt_ctrl = IDLE;
        nxt_gnt  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl    <= IDLE;
      det     <= INIT;
      gnt     <= 2'b00;
      gid_cur <= 1'b0;
      gid_out <= 1'b0;
      ptr     <= 1'b0;
      count   <= '0;
    end else begin
      ctrl    <= nxt_ctrl;
      det     <= nxt_det;
      gnt     <= nxt_gnt;
      gid_cur <= nxt_gid_cur;
      gid_out <= nxt_gid_out;
      ptr     <= nxt_ptr;
      count   <= nxt_count;
    end
  end

  assign bus.o_gnt   = gnt;
  assign bus.o_ready = (ctrl == RUN);
  assign bus.o_match = (det == OK0) || (det == OK1);
  assign bus.o_done  = (ctrl == DONE);
  assign bus.o_gid   = gid_out;
  assign bus.o_count = count;

endmodule

// File: tb/tb_fsm_detect_arbiter.sv
// Directed bench for fsm_detect_arbiter: an 8-bit and a 2-bit counter instance see identical
// stimulus; burst results are queued at burst start and compared when o_done appears.
module tb_fsm_detect_arbiter;

  logic       clk;
  logic       rstn;
  logic [1:0] req, valid, sym0, sym1, last;

  typedef struct {
    logic gid;
    int   cnt8;
    int   cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  fsm_detect_arbiter_if #(.CNT_W(8)) bus8();
  fsm_detect_arbiter_if #(.CNT_W(2)) bus2();

  assign bus8.i_req   = req;
  assign bus8.i_valid = valid;
  assign bus8.i_sym0  = sym0;
  assign bus8.i_sym1  = sym1;
  assign bus8.i_last  = last;
  assign bus2.i_req   = req;
  assign bus2.i_valid = valid;
  assign bus2.i_sym0  = sym0;
  assign bus2.i_sym1  = sym1;
  assign bus2.i_last  = last;

  fsm_detect_arbiter #(.CNT_W(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));
  fsm_detect_arbiter #(.CNT_W(2)) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [1:0] s, input logic lst);
    valid = id ? 2'b10 : 2'b01;
    if (id) sym1 = s; else sym0 = s;
    last = lst ? valid : 2'b00;
    tick();
    valid = 2'b00;
    last  = 2'b00;
  endtask

  task automatic step(input string tag, input logic m, input int c);
    check({tag, "_match"}, bus8.o_match, m);
    check({tag, "_count"}, bus8.o_count, c);
  endtask

  task automatic push_exp(input logic gid, input int cnt);
    exp_t e;
    e.gid  = gid;
    e.cnt8 = cnt;
    e.cnt2 = (cnt > 3) ? 3 : cnt;
    exp_q.push_back(e);
  endtask

  // Expect o_done in the cycle right after the last symbol; a late pulse is still scored.
  task automatic expect_done(input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    while (!bus8.o_done && waited < 4) begin
      tick();
      waited++;
    end
    check({tag, "_done"}, bus8.o_done, 1);
    check({tag, "_done_lat"}, waited, 0);
    check({tag, "_done_gnt"}, bus8.o_gnt, 2'b00);
    check({tag, "_done_rdy"}, bus8.o_ready, 0);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_sb: observed o_done with empty scoreboard, expected queued result", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_gid"}, bus8.o_gid, e.gid);
      check({tag, "_cnt8"}, bus8.o_count, e.cnt8);
      check({tag, "_cnt2"}, bus2.o_count, e.cnt2);
    end
  endtask

  initial begin
    rstn  = 1'b0;
    req   = 2'b00;
    valid = 2'b00;
    sym0  = 2'b00;
    sym1  = 2'b00;
    last  = 2'b00;
    #12;
    check("rst_gnt", bus8.o_gnt, 2'b00);
    check("rst_ready", bus8.o_ready, 0);
    check("rst_match", bus8.o_match, 0);
    check("rst_done", bus8.o_done, 0);
    check("rst_gid", bus8.o_gid, 0);
    check("rst_count", bus8.o_count, 0);
    tick();
    rstn = 1'b1;
    tick();

    // Both request: pointer favours requester 0; burst 00,01,10,11,11.
    req = 2'b11;
    tick();
    check("b0_gnt", bus8.o_gnt, 2'b01);
    check("b0_ready", bus8.o_ready, 1);
    push_exp(1'b0, 3);
    send(1'b0, 2'b00, 1'b0); step("b0_s1", 0, 0);
    send(1'b0, 2'b01, 1'b0); step("b0_s2", 1, 1);
    send(1'b0, 2'b10, 1'b0); step("b0_s3", 0, 1);
    send(1'b0, 2'b11, 1'b0); step("b0_s4", 1, 2);
    send(1'b0, 2'b11, 1'b1); step("b0_s5", 1, 3);
    expect_done("b0");
    tick();
    check("b0_idle_done", bus8.o_done, 0);
    check("b0_idle_gnt", bus8.o_gnt, 2'b00);
    check("b0_idle_gid", bus8.o_gid, 0);
    tick();
    check("rr_gnt1", bus8.o_gnt, 2'b10);
    check("b1_count_clr", bus8.o_count, 0);

    // Requester 1 burst with bubbles; requester 0 lines toggle but must be ignored.
    push_exp(1'b1, 1);
    send(1'b1, 2'b10, 1'b0); step("b1_s1", 0, 0);
    for (int i = 0; i < 3; i++) begin
      valid = 2'b01;
      last  = 2'b01;
      sym0  = 2'b00;
      sym1  = 2'b11;
      tick();
      step("b1_bubble", 0, 0);
      check("b1_bubble_rdy", bus8.o_ready, 1);
      check("b1_bubble_done", bus8.o_done, 0);
    end
    valid = 2'b00;
    last  = 2'b00;
    send(1'b1, 2'b10, 1'b1); step("b1_s2", 1, 1);
    expect_done("b1");
    req = 2'b01;
    tick();
    check("b1_idle_gnt", bus8.o_gnt, 2'b00);
    check("b1_idle_gid", bus8.o_gid, 1);
    check("b1_idle_match", bus8.o_match, 1);
    tick();
    check("rr_gnt0", bus8.o_gnt, 2'b01);
    check("b2_match_clr", bus8.o_match, 0);

    // Six 00 symbols: five matches, 2-bit instance saturates at 3.
    push_exp(1'b0, 5);
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 2'b00, (i == 5));
      step("b2_s", (i == 0) ? 0 : 1, i);
    end
    expect_done("b2");
    req = 2'b10;
    tick();
    tick();
    check("b3_gnt", bus8.o_gnt, 2'b10);
    check("b3_count_clr8", bus8.o_count, 0);
    check("b3_count_clr2", bus2.o_count, 0);

    // Abort: requester 1 drops its request mid-burst while requester 0 waits.
    req = 2'b11;
    send(1'b1, 2'b00, 1'b0); step("b3_s1", 0, 0);
    send(1'b1, 2'b11, 1'b0); step("b3_s2", 0, 0);
    req = 2'b01;
    tick();
    check("abort_gnt", bus8.o_gnt, 2'b00);
    check("abort_done", bus8.o_done, 0);
    check("abort_ready", bus8.o_ready, 0);
    tick();
    check("abort_next_gnt", bus8.o_gnt, 2'b01);
    check("abort_next_done", bus8.o_done, 0);

    // Reset in the middle of a requester 0 burst.
    send(1'b0, 2'b00, 1'b0); step("b4_s1", 0, 0);
    send(1'b0, 2'b01, 1'b0); step("b4_s2", 1, 1);
    rstn = 1'b0;
    #1;
    check("mrst_gnt", bus8.o_gnt, 2'b00);
    check("mrst_ready", bus8.o_ready, 0);
    check("mrst_done", bus8.o_done, 0);
    check("mrst_count", bus8.o_count, 0);
    check("mrst_match", bus8.o_match, 0);
    req = 2'b00;
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_gnt", bus8.o_gnt, 2'b00);
    check("post_rst_ready", bus8.o_ready, 0);
    check("post_rst_done", bus8.o_done, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
